// File: rtl/switch_debouncer.sv
// Two-channel slide-switch synchroniser and debouncer with optional press/release pulses.
// Pulse outputs are built only when SWITCH_DEBOUNCE_EDGE_EN is defined; otherwise they are tied to 0.
module switch_debouncer #(
    parameter int DEBOUNCE_LIMIT = 240000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    output logic o_Switch_1,
    output logic o_Switch_2,
    output logic o_Press_1,
    output logic o_Press_2,
    output logic o_Release_1,
    output logic o_Release_2
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    endfunction

    logic [1:0] raw;
    logic [1:0] state_v;
    logic [1:0] press_v;
    logic [1:0] rel_v;

    assign raw = {i_Switch_2, i_Switch_1};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_chain;
        logic [CNT_W-1:0]       cnt;
        logic                   state_q;
        logic                   sync;

        assign sync        = sync_chain[SYNC_STAGES-1];
        assign state_v[ch] = state_q;

        // synchroniser, stability counter, stable-state bit
        always_ff @(posedge i_Clk) begin
            if (!i_Rst_n) begin
                sync_chain <= '0;
                cnt        <= '0;
                state_q    <= 1'b0;
            end else begin
                sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw[ch]};
                if (sync == state_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    state_q <= sync;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt_sat_inc(cnt);
                end
            end
        end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
        logic state_d;
        logic press_q;
        logic rel_q;

        // edge pulses, one cycle after the state flip; reset clears the history so no pulse follows it
        always_ff @(posedge i_Clk) begin
            if (!i_Rst_n) begin
                state_d <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_d <= state_q;
                press_q <= state_q & ~state_d;
                rel_q   <= ~state_q & state_d;
            end
        end

        assign press_v[ch] = press_q;
        assign rel_v[ch]   = rel_q;
`else
        assign press_v[ch] = 1'b0;
        assign rel_v[ch]   = 1'b0;
`endif
    end

    assign o_Switch_1  = state_v[0];
    assign o_Switch_2  = state_v[1];
    assign o_Press_1   = press_v[0];
    assign o_Press_2   = press_v[1];
    assign o_Release_1 = rel_v[0];
    assign o_Release_2 = rel_v[1];

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus randomized switch activity
// checked every cycle against a window-based behavioural model.
`timescale 1ns/1ps
module tb_switch_debouncer;

    localparam int LIMIT  = 4;
    localparam int STAGES = 2;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sw1   = 1'b0;
    logic sw2   = 1'b0;
    logic o_sw1, o_sw2, o_pr1, o_pr2, o_rl1, o_rl2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES   (STAGES)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Switch_1 (sw1),
        .i_Switch_2 (sw2),
        .o_Switch_1 (o_sw1),
        .o_Switch_2 (o_sw2),
        .o_Press_1  (o_pr1),
        .o_Press_2  (o_pr2),
        .o_Release_1(o_rl1),
        .o_Release_2(o_rl2)
    );

    // Reference model: raw samples pass through a STAGES-deep delay queue; the stable level
    // flips when the last LIMIT delayed samples all disagree with it.
    bit m_raw_q [2][$];
    bit m_win   [2][$];
    bit m_st    [2];
    bit m_st_pp [2];
    bit m_press [2];
    bit m_rel   [2];
    bit m_rst1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit r1, input bit r2);
        bit raw [2];
        bit prev;
        bit pp;
        bit s;
        bit all_diff;
        raw[0] = r1;
        raw[1] = r2;
        for (int c = 0; c < 2; c++) begin
            prev = m_st[c];
            pp   = m_st_pp[c];
            if (rst) begin
                m_raw_q[c].delete();
                m_win[c].delete();
                for (int i = 0; i < STAGES; i++) m_raw_q[c].push_back(1'b0);
                for (int i = 0; i < LIMIT; i++)  m_win[c].push_back(1'b0);
                m_st[c]    = 1'b0;
                m_press[c] = 1'b0;
                m_rel[c]   = 1'b0;
            end else begin
                s = m_raw_q[c].pop_front();
                m_raw_q[c].push_back(raw[c]);
                m_win[c].push_back(s);
                void'(m_win[c].pop_front());
                all_diff = 1'b1;
                for (int i = 0; i < m_win[c].size(); i++)
                    if (m_win[c][i] == m_st[c]) all_diff = 1'b0;
                if (all_diff) m_st[c] = s;
                m_press[c] = !m_rst1 && prev && !pp;
                m_rel[c]   = !m_rst1 && !prev && pp;
            end
            m_st_pp[c] = prev;
        end
        m_rst1 = rst;
    endtask

    task automatic step(input bit rst, input bit s1, input bit s2);
        rst_n = !rst;
        sw1   = s1;
        sw2   = s2;
        @(posedge clk);
        model_update(rst, s1, s2);
        @(negedge clk);
        chk("model_sw1", o_sw1, m_st[0]);
        chk("model_sw2", o_sw2, m_st[1]);
        chk("model_press1", o_pr1, EDGE_EN && m_press[0]);
        chk("model_press2", o_pr2, EDGE_EN && m_press[1]);
        chk("model_rel1", o_rl1, EDGE_EN && m_rel[0]);
        chk("model_rel2", o_rl2, EDGE_EN && m_rel[1]);
        chk("excl1", o_pr1 & o_rl1, 0);
        chk("excl2", o_pr2 & o_rl2, 0);
    endtask

    initial begin
        int press_cnt;
        int hold [2];
        bit lvl  [2];

        // reset with both switches held high
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk($sformatf("rst_outs_c%0d", i), {o_sw1, o_sw2, o_pr1, o_pr2, o_rl1, o_rl2}, 0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // clean press on switch 1
        for (int e = 0; e < 9; e++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("clean_sw1_e%0d", e), o_sw1, e >= 5);
            chk($sformatf("clean_press1_e%0d", e), o_pr1, EDGE_EN && e == 6);
            chk($sformatf("clean_sw2_e%0d", e), o_sw2, 0);
        end
        repeat (8) step(1'b0, 1'b0, 1'b0);
        chk("released_sw1", o_sw1, 0);

        // bounce rejection
        press_cnt = 0;
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 3; j++) begin
                step(1'b0, (b % 2 == 0), 1'b0);
                press_cnt += int'(o_pr1);
                chk("bounce_sw1", o_sw1, 0);
            end
        end
        for (int e = 0; e < 10; e++) begin
            step(1'b0, 1'b1, 1'b0);
            press_cnt += int'(o_pr1);
            chk($sformatf("settle_sw1_e%0d", e), o_sw1, e >= 5);
        end
        chk("bounce_press_cnt", press_cnt, EDGE_EN ? 1 : 0);

        // dual-channel simultaneous release
        repeat (8) step(1'b0, 1'b1, 1'b1);
        chk("dual_pre_sw2", o_sw2, 1);
        for (int e = 0; e < 9; e++) begin
            step(1'b0, 1'b0, 1'b0);
            chk($sformatf("dual_sw1_e%0d", e), o_sw1, e < 5);
            chk($sformatf("dual_sw2_e%0d", e), o_sw2, e < 5);
            chk($sformatf("dual_rel1_e%0d", e), o_rl1, EDGE_EN && e == 6);
            chk($sformatf("dual_rel2_e%0d", e), o_rl2, EDGE_EN && e == 6);
        end

        // reset in the middle of a qualification
        for (int e = 0; e < 3; e++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("midrst_sw1", o_sw1, 0);
        chk("midrst_press1", o_pr1, 0);
        for (int e = 0; e < 9; e++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("postrst_sw1_e%0d", e), o_sw1, e >= 5);
            chk($sformatf("postrst_press1_e%0d", e), o_pr1, EDGE_EN && e == 6);
        end

        // randomized hold lengths around the debounce limit, with occasional resets
        hold[0] = 0;
        hold[1] = 0;
        lvl[0]  = 1'b0;
        lvl[1]  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    lvl[c]  = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 10));
                end
                hold[c]--;
            end
            step($urandom_range(0, 199) == 0, lvl[0], lvl[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
